id_fwd_hazard_unit: RTL
=======================

// Module: id_fwd_hazard_unit
// PURPOSE
//  ID-stage operand forwarding plus hazard detection for branch compare and early operands.
//  - NUM_SRC source operands; NUM_STG producer stages, priority by age (stage 0 = youngest).
//  - Forwarded operand data is muxed here; a stall is raised when a match exists but data is not ready.
//  - Per-register scoreboard covers the multi-cycle divide unit, which writes back out of band.
//  - Saturating stall-cycle counter for performance monitoring.
// PARAMETERS
//  XLEN     32  operand data width
//  NUM_SRC  2   number of ID source operands
//  NUM_STG  3   producer stages: 0=ID/EX, 1=EX/MEM, 2=MEM/WB
//  NREGS    32  architectural registers; AW=$clog2(NREGS)
//  CNT_W    32  stall counter width
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              asynchronous, active-high reset
//  id_valid     in   1              IF/ID holds a valid instruction
//  id_flush     in   1              ID instruction squashed this cycle
//  id_rs        in   NUM_SRC*AW     source register indices; slot i = [i*AW +: AW]
//  id_rs_used   in   NUM_SRC        slot i is read by the instruction
//  rf_rdata     in   NUM_SRC*XLEN   register-file read data per slot
//  stg_we       in   NUM_STG        stage s writes a register
//  stg_rd       in   NUM_STG*AW     stage s destination
//  stg_dvalid   in   NUM_STG        stage s result is available now (0 for ID/EX, and for a load in EX/MEM)
//  stg_wdata    in   NUM_STG*XLEN   stage s result
//  mc_issue     in   1              multi-cycle op issued this cycle
//  mc_issue_rd  in   AW             multi-cycle op destination
//  mc_done      in   1              multi-cycle op writes back this cycle
//  mc_done_rd   in   AW             destination being written back
//  op_data      out  NUM_SRC*XLEN   resolved operand per slot
//  fwd_sel      out  NUM_SRC*(NUM_STG+1)  one-hot per slot: bit s = stage s; bit NUM_STG = register file
//  stall        out  1              hold IF/ID; insert bubble into ID/EX
//  sb_busy      out  NREGS          scoreboard pending-write bits
//  stall_cnt    out  CNT_W          stall cycles since reset
// BEHAVIOUR
//  Forwarding (combinational, 0 latency):
//   - hit[i][s] = stg_we[s] & stg_rd[s]!=0 & stg_rd[s]==rs[i].
//   - Winner = lowest s with a hit.
//   - No hit, rs==0, or slot unused: fwd_sel selects the RF; op_data=rf_rdata (rs==0 still passes RF data).
//   - Winner with dvalid=1: op_data=stg_wdata[winner].
//   - Winner with dvalid=0: slot not ready; op_data=stg_wdata[winner] (don't-care); fwd_sel still marks winner.
//  Stall:
//   - stall = id_valid & ~id_flush & OR_i(used[i] & (notready[i] | (sb_busy[rs[i]] & rs[i]!=0))).
//   - Stall does not gate any input; upstream holds ID steady. Older stages keep advancing.
//   - Repeated stalls therefore resolve, e.g. load-then-branch = 2 stall cycles.
//  Scoreboard:
//   - NREGS flops; bit 0 is hard-wired 0.
//   - On clk: mc_done clears bit mc_done_rd; mc_issue sets bit mc_issue_rd.
//   - Same register in both in the same cycle -> bit ends 1 (issue wins).
//   - Scoreboard is not cleared by id_flush; the issued op completes regardless.
//   - sb_busy bit read in ID is the registered value; a same-cycle mc_done does NOT unstall until the next cycle.
//   - The mc_done writeback also appears as a stage entry, so no bypass is needed.
//  Stall counter:
//   - Increments by 1 on each clk with stall=1.
//   - Saturates at 2^CNT_W-1, no wrap.
//  Reset:
//   - rst asserted (any time, async): sb_busy=0, stall_cnt=0 immediately.
//   - Combinational outputs follow inputs; with id_valid=0, stall=0.
//   - Reset mid multi-cycle op drops pending bits; a later mc_done clearing a 0 bit is harmless.
// TESTING
//  1. x5 in EX/MEM (dvalid=1, data=0xAAAA) and MEM/WB (data=0xBBBB), rs1=5 -> op_data0=0xAAAA, fwd_sel0=0b0010, stall=0.
//  2. Load to x7 in ID/EX, branch in ID uses x7 -> stall=1; next cycle load in EX/MEM dvalid=0 -> stall=1; then MEM/WB -> stall=0, stall_cnt=2.
//  3. rs1=0 with stg_we=1, rd=0 in all stages -> RF select, stall=0; stg_we=0 with matching rd -> no forward.
//  4. mc_issue rd=9, 12 cycles later mc_done rd=9; ID reads x9 from cycle 1 -> stall for exactly the busy window; clears the cycle after done.
//  5. mc_done rd=3 and mc_issue rd=3 same clk -> sb_busy[3]=1; rst pulse mid-op -> sb_busy=0, stall_cnt=0 asynchronously.
//  6. Force stall for 2^CNT_W cycles (CNT_W=4 build) -> stall_cnt holds at 15; id_flush=1 with hazard -> stall=0.

Source files
------------

// File: rtl/id_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// id_fwd_hazard_unit
//
// Decode-stage operand forwarding and hazard detection. The unit resolves
// operands early enough for branch compares and early-use operands in ID.
//
// For every ID source slot the unit looks for the youngest in-flight producer
// of the same register among NUM_STG pipeline stages (stage 0 = ID/EX is the
// youngest). If the youngest matching stage already holds its result, the
// operand comes from that stage. Otherwise the slot is not ready and the unit
// stalls ID.
//
// Results of the multi-cycle divide unit write back outside the normal pipe
// order. The unit tracks them in a per-register scoreboard of pending-write
// bits. Any ID read of a pending register stalls until the bit clears.
//
// A saturating counter records how many cycles ID has spent stalled.
//
// Parameters
//   XLEN     operand data width
//   NUM_SRC  number of ID source operand slots
//   NUM_STG  producer stages (0=ID/EX, 1=EX/MEM, 2=MEM/WB)
//   NREGS    architectural registers (x0 reads as zero, never forwarded)
//   CNT_W    stall counter width
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   id_valid_i      IF/ID holds a valid instruction
//   id_flush_i      ID instruction squashed this cycle (suppresses stall)
//   id_rs_i         source register index per slot, slot i = [i*AW +: AW]
//   id_rs_used_i    slot i is actually read by the instruction
//   rf_rdata_i      register-file read data per slot
//   stg_we_i        stage s writes a register
//   stg_rd_i        stage s destination register
//   stg_dvalid_i    stage s result is available this cycle
//   stg_wdata_i     stage s result data
//   mc_issue_i      multi-cycle op issued this cycle
//   mc_issue_rd_i   destination register of the issued multi-cycle op
//   mc_done_i       multi-cycle op writes back this cycle
//   mc_done_rd_i    destination register being written back
//   op_data_o       resolved operand per slot
//   fwd_sel_o       one-hot source per slot: bit s = stage s, bit NUM_STG = RF
//   stall_o         hold IF/ID and insert a bubble into ID/EX
//   sb_busy_o       scoreboard pending-write bits (bit 0 always 0)
//   stall_cnt_o     saturating count of stalled cycles since reset
// -----------------------------------------------------------------------------
module id_fwd_hazard_unit #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 3,
    parameter int NREGS   = 32,
    parameter int CNT_W   = 32,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid_i,
    input  logic                           id_flush_i,
    input  logic [NUM_SRC*AW-1:0]          id_rs_i,
    input  logic [NUM_SRC-1:0]             id_rs_used_i,
    input  logic [NUM_SRC*XLEN-1:0]        rf_rdata_i,
    input  logic [NUM_STG-1:0]             stg_we_i,
    input  logic [NUM_STG*AW-1:0]          stg_rd_i,
    input  logic [NUM_STG-1:0]             stg_dvalid_i,
    input  logic [NUM_STG*XLEN-1:0]        stg_wdata_i,
    input  logic                           mc_issue_i,
    input  logic [AW-1:0]                  mc_issue_rd_i,
    input  logic                           mc_done_i,
    input  logic [AW-1:0]                  mc_done_rd_i,
    output logic [NUM_SRC*XLEN-1:0]        op_data_o,
    output logic [NUM_SRC*(NUM_STG+1)-1:0] fwd_sel_o,
    output logic                           stall_o,
    output logic [NREGS-1:0]               sb_busy_o,
    output logic [CNT_W-1:0]               stall_cnt_o
);

    // Scoreboard state and stall counter
    logic [NREGS-1:0] sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Per-slot hazard flags, OR-reduced into the stall request
    logic [NUM_SRC-1:0] hazard;

    // -------------------------------------------------------------------------
    // Per-slot forwarding network
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
        logic [AW-1:0]      rs;
        logic [NUM_STG-1:0] hit;
        logic [NUM_STG:0]   sel;
        logic [XLEN-1:0]    data;
        logic               not_ready;
        logic               sb_pending;

        assign rs = id_rs_i[i*AW +: AW];

        // A stage that targets x0 never matches. This also keeps rs==0 on
        // the register-file path.
        for (genvar s = 0; s < NUM_STG; s++) begin : g_hit
            assign hit[s] = stg_we_i[s]
                          && (stg_rd_i[s*AW +: AW] != '0)
                          && (stg_rd_i[s*AW +: AW] == rs);
        end

        // NOTE: every value written in this block gets a default first, so
        // paths with no hit cannot infer a latch.
        always_comb begin
            sel            = '0;
            sel[NUM_STG]   = 1'b1;
            data           = rf_rdata_i[i*XLEN +: XLEN];
            not_ready      = 1'b0;
            if (id_rs_used_i[i]) begin
                // Scan from the oldest stage to the youngest. A younger hit
                // overwrites an older one, so the lowest matching stage wins.
                for (int s = NUM_STG - 1; s >= 0; s--) begin
                    if (hit[s]) begin
                        sel       = '0;
                        sel[s]    = 1'b1;
                        data      = stg_wdata_i[s*XLEN +: XLEN];
                        not_ready = ~stg_dvalid_i[s];
                    end
                end
            end
        end

        // The scoreboard is read from the registered value. A writeback in
        // this same cycle does not clear the hazard until the next cycle.
        assign sb_pending = id_rs_used_i[i] && (rs != '0) && sb_q[rs];

        assign hazard[i]                                = not_ready | sb_pending;
        assign op_data_o[i*XLEN +: XLEN]                = data;
        assign fwd_sel_o[i*(NUM_STG+1) +: (NUM_STG+1)]  = sel;
    end

    // The stall does not gate any input. Upstream holds ID steady while the
    // older stages keep draining, so a repeated hazard resolves by itself.
    assign stall_o = id_valid_i && !id_flush_i && (|hazard);

    // -------------------------------------------------------------------------
    // Multi-cycle scoreboard
    // -------------------------------------------------------------------------
    // The clear is applied before the set, so when the same register is both
    // written back and reissued in one cycle, the issue wins. A flush does
    // not touch this state: the issued op runs to completion regardless.
    always_comb begin
        sb_d = sb_q;
        if (mc_done_i) begin
            sb_d[mc_done_rd_i] = 1'b0;
        end
        if (mc_issue_i) begin
            sb_d[mc_issue_rd_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // NOTE: this small register array is reset on purpose. A pending bit
    // left over from before reset would stall ID on a write that will never
    // come back. A later writeback clearing an already-clear bit does no harm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment, so every
            // flop samples the pre-edge values consistently.
            sb_q <= sb_d;
        end
    end

    assign sb_busy_o = sb_q;

    // -------------------------------------------------------------------------
    // Saturating stall-cycle counter
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (stall_o && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule
